// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, store lane masks, wait limit.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    localparam int WAIT_MAX = 7;

    // Halfwords must sit on even bytes, words on word boundaries; bytes are always aligned.
    function automatic logic misaligned(input logic [3:0] we, input logic [1:0] off);
        return ((we == LANE_H) && off[0]) || ((we == LANE_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Byte-enabled synchronous single-port RAM with a registered read port (read-before-write).
module dmem_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] idx,
    input  logic [3:0]        lane_en,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: single-cycle stores, loads with WAIT extra cycles of latency.
// Optional misaligned-store suppression and mem_err pulse with DMEM_MISALIGN_CHK_EN.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_oe,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_we,
    output logic [31:0] mem_rdata,
`ifdef DMEM_MISALIGN_CHK_EN
    output logic        mem_err,
`endif
    output logic        mem_ready
);

    localparam int         WAIT_EFF = (WAIT > WAIT_MAX) ? WAIT_MAX : WAIT;
    localparam logic [2:0] CNT_LD   = (WAIT_EFF > 0) ? 3'(WAIT_EFF - 1) : 3'd0;

    state_t            state, state_d;
    logic [2:0]        cnt, cnt_d;
    logic              resp, resp_d;
    logic              acc, load_acc, store_acc, store_ok;
    logic [3:0]        lanes;
    logic [31:0]       wdata_sh;
    logic [ADDR_W-1:0] ram_idx, idx_hold;
    logic [1:0]        off_hold;
    logic [31:0]       ram_q, load_word, rdata_hold;
    logic              unused_hi;

    assign unused_hi = ^mem_addr[31:ADDR_W+2];

    assign acc       = mem_oe && (state == S_IDLE);
    assign load_acc  = acc && (mem_we == 4'b0000);
    assign store_acc = acc && (mem_we != 4'b0000);

`ifdef DMEM_MISALIGN_CHK_EN
    assign store_ok = !misaligned(mem_we, mem_addr[1:0]);
`else
    assign store_ok = 1'b1;
`endif

    always_comb begin
        lanes    = 4'b0000;
        wdata_sh = mem_wdata << {mem_addr[1:0], 3'b000};
        if (store_acc && store_ok) begin
            lanes = mem_we << mem_addr[1:0];
        end
    end

    // While a load is in flight the RAM keeps re-reading the captured word.
    assign ram_idx = (state == S_IDLE) ? mem_addr[ADDR_W+1:2] : idx_hold;

    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .idx     (ram_idx),
        .lane_en (lanes),
        .wdata   (wdata_sh),
        .rdata   (ram_q)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        resp_d  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_acc) begin
                    if (WAIT_EFF == 0) begin
                        resp_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_LD;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_d = S_RESP;
                    resp_d  = 1'b1;
                end else begin
                    cnt_d = cnt - 3'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            resp       <= 1'b0;
            rdata_hold <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            resp  <= resp_d;
            if (resp) begin
                rdata_hold <= load_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_acc) begin
            idx_hold <= mem_addr[ADDR_W+1:2];
            off_hold <= mem_addr[1:0];
        end
    end

    assign load_word = ram_q >> {off_hold, 3'b000};
    assign mem_rdata = resp ? load_word : rdata_hold;
    assign mem_ready = (state != S_WAIT);

`ifdef DMEM_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= store_acc && !store_ok;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: one instance with WAIT=0 and one with WAIT=3, byte-level memory model.
`timescale 1ns/1ps
module tb_dmem_resp;

    localparam int ADDR_W = 12;
    localparam int NW     = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic [1:0]  rst_n = 2'b00;
    logic [1:0]  oe = 2'b00;
    logic [1:0]  ready;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  we = 4'd0;
    logic [31:0] rdata0, rdata1;
`ifdef DMEM_MISALIGN_CHK_EN
    logic [1:0]  err;
`endif

    always #5 clk = ~clk;

    dmem_resp #(.ADDR_W(ADDR_W), .WAIT(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n[0]),
        .mem_addr  (addr),
        .mem_oe    (oe[0]),
        .mem_wdata (wdata),
        .mem_we    (we),
        .mem_rdata (rdata0),
`ifdef DMEM_MISALIGN_CHK_EN
        .mem_err   (err[0]),
`endif
        .mem_ready (ready[0])
    );

    dmem_resp #(.ADDR_W(ADDR_W), .WAIT(3)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n[1]),
        .mem_addr  (addr),
        .mem_oe    (oe[1]),
        .mem_wdata (wdata),
        .mem_we    (we),
        .mem_rdata (rdata1),
`ifdef DMEM_MISALIGN_CHK_EN
        .mem_err   (err[1]),
`endif
        .mem_ready (ready[1])
    );

    typedef struct {
        int          d;
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mm [2][NW];
    logic [31:0] hold [2] = '{32'd0, 32'd0};
    int          st_lo [2] = '{-1, -1};
    int          st_hi [2] = '{-1, -1};
    int          err_cyc [2] = '{-1, -1};
    int          cyc = 0;
    int          nchk = 0;
    int          npass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wt(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic logic [31:0] exp_ready(input int d);
        return (cyc >= st_lo[d] && cyc <= st_hi[d]) ? 32'd0 : 32'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Issue one request to instance d starting at a falling edge; returns at the falling edge
    // where the next request may be driven. Loads on the waiting instance stay held on mem_oe
    // through WAIT and RESP, like a stalled initiator.
    task automatic op(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm);
        int          idx, off;
        logic [31:0] word, res;
        bit          skip;
        idx = int'(a[ADDR_W+1:2]);
        off = int'(a[1:0]);
        addr = a; wdata = wd; we = wm;
        oe = 2'b00; oe[d] = 1'b1;
        if (wm != 4'b0000) begin
            skip = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
            if ((wm == 4'b0011 && (off % 2) == 1) || (wm == 4'b1111 && off != 0)) begin
                skip = 1'b1;
                err_cyc[d] = cyc + 1;
            end
`endif
            if (!skip) begin
                for (int i = 0; i < 4; i++) begin
                    if (wm[i] && (i + off) < 4) mm[d][idx][8*(i+off) +: 8] = wd[8*i +: 8];
                end
            end
            @(negedge clk);
        end else begin
            word = mm[d][idx];
            res  = 32'd0;
            for (int i = off; i < 4; i++) res[8*(i-off) +: 8] = word[8*i +: 8];
            sbq.push_back('{d, cyc + 1 + wt(d), res});
            if (wt(d) > 0) begin
                st_lo[d] = cyc + 1;
                st_hi[d] = cyc + wt(d);
                repeat (wt(d) + 2) @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // Load on the WAIT=3 instance, then reset it during the second wait cycle.
    task automatic reset_mid_wait();
        addr = 32'h10; we = 4'd0; wdata = 32'd0;
        oe = 2'b10;
        st_lo[1] = cyc + 1;
        st_hi[1] = cyc + 3;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n[1] = 1'b0;
        #1;
        chk("rst_mid_ready", {31'd0, ready[1]}, 32'd1);
        chk("rst_mid_rdata", rdata1, 32'd0);
        st_lo[1] = -1;
        st_hi[1] = -1;
        hold[1]  = 32'd0;
        oe = 2'b00;
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(negedge clk);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                if (sbq[0].due < cyc) begin
                    nchk++;
                    $display("FAIL sb_order: response for cycle %0d not seen, now %0d", sbq[0].due, cyc);
                end else begin
                    hold[sbq[0].d] = sbq[0].data;
                end
                sbq.delete(0);
            end
            chk("rdata0", rdata0, hold[0]);
            chk("rdata1", rdata1, hold[1]);
            chk("ready0", {31'd0, ready[0]}, exp_ready(0));
            chk("ready1", {31'd0, ready[1]}, exp_ready(1));
`ifdef DMEM_MISALIGN_CHK_EN
            chk("err0", {31'd0, err[0]}, (cyc == err_cyc[0]) ? 32'd1 : 32'd0);
            chk("err1", {31'd0, err[1]}, (cyc == err_cyc[1]) ? 32'd1 : 32'd0);
`endif
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", npass, nchk);
        $fatal(1);
    end

    initial begin : driver
        logic [31:0] a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 2'b11;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++) op(d, 32'(w * 4), $urandom, 4'b1111);

            op(d, 32'h10, 32'hDEADBEEF, 4'b1111);
            op(d, 32'h10, 32'd0, 4'b0000);
            op(d, 32'h13, 32'h000000AA, 4'b0001);
            op(d, 32'h10, 32'd0, 4'b0000);
            op(d, 32'h13, 32'd0, 4'b0000);
            op(d, 32'h10, 32'd0, 4'b0000);

            if (d == 1) begin
                reset_mid_wait();
                op(d, 32'h10, 32'd0, 4'b0000);
            end

            op(d, 32'h4010, 32'h12345678, 4'b1111);
            op(d, 32'h0010, 32'd0, 4'b0000);
            op(d, 32'h12, 32'h11111111, 4'b1111);
            op(d, 32'h10, 32'd0, 4'b0000);

            for (int n = 0; n < 300; n++) begin
                a = $urandom;
                a[ADDR_W+1:6] = '0;
                case ($urandom_range(0, 3))
                    0:       op(d, a, $urandom, 4'b0001);
                    1:       op(d, a, $urandom, 4'b0011);
                    2:       op(d, a, $urandom, 4'b1111);
                    default: op(d, a, $urandom, 4'b0000);
                endcase
                if ($urandom_range(0, 7) == 0) begin
                    oe = 2'b00;
                    @(negedge clk);
                end
            end
            oe = 2'b00;
            repeat (2) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
